// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings,
// default watchdog width and an index-width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_W_DEFAULT = 20;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, or ptr
// itself when the lock carry-over gives it priority.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             hold_prio,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        winner_idx = ptr;
        if (hold_prio && req[ptr]) begin
            found = 1'b1;
        end else begin
            // Scan starts one past ptr so the previous winner is checked last.
            for (int k = 1; k <= N_REQ; k++) begin
                cand     = (int'(ptr) + k) % N_REQ;
                cand_idx = IDX_W'(cand);
                if (!found && req[cand_idx]) begin
                    found      = 1'b1;
                    winner_idx = cand_idx;
                end
            end
        end
        winner = found ? (N_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto one UART transmitter with
// round-robin fairness, packet lock and a per-byte watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   lock,
    input  logic [N_REQ*8-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_ack
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     ptr, owner, pick_idx;
    logic [N_REQ-1:0]     pick;
    logic                 lock_carry;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 start_xfer, end_done, end_err;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .ptr        (ptr),
        .hold_prio  (lock_carry),
        .winner     (pick),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_xfer = 1'b0;
        end_done   = 1'b0;
        end_err    = 1'b0;
        case (state)
            IDLE: begin
                if ((|req) && !tx_busy) begin
                    state_nxt  = START;
                    start_xfer = 1'b1;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                // An ack coinciding with watchdog expiry still counts as sent.
                if (tx_ack) begin
                    state_nxt = IDLE;
                    end_done  = 1'b1;
                end else if (&wdog) begin
                    state_nxt = IDLE;
                    end_err   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_en = (state == START);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            tx_data    <= '0;
            ptr        <= IDX_W'(N_REQ - 1);
            owner      <= '0;
            lock_carry <= 1'b0;
            wdog       <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            if (start_xfer) begin
                grant   <= pick;
                owner   <= pick_idx;
                tx_data <= req_data[{pick_idx, 3'b000} +: 8];
            end
            if (state == START)     wdog <= '0;
            else if (state == WAIT) wdog <= wdog + 1'b1;
            if (end_done) begin
                done       <= grant;
                ptr        <= owner;
                lock_carry <= lock[owner];
                grant      <= '0;
            end
            if (end_err) begin
                err        <= grant;
                ptr        <= owner;
                lock_carry <= 1'b0;
                grant      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: one default instance and
// one with a 4-bit watchdog for the timeout scenario.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, grant, done, err;
    logic [31:0] req_data;
    logic        tx_en, tx_busy, tx_ack;
    logic [7:0]  tx_data;

    logic [3:0]  w_req, w_lock, w_grant, w_done, w_err;
    logic [31:0] w_data;
    logic        w_tx_en, w_busy, w_ack;
    logic [7:0]  w_tx_data;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .tx_en(tx_en),
        .tx_data(tx_data), .tx_busy(tx_busy), .tx_ack(tx_ack)
    );

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_W(4)) dut_wd (
        .clk(clk), .rst(rst), .req(w_req), .lock(w_lock), .req_data(w_data),
        .grant(w_grant), .done(w_done), .err(w_err), .tx_en(w_tx_en),
        .tx_data(w_tx_data), .tx_busy(w_busy), .tx_ack(w_ack)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic pop_exp(input string tag, output exp_t e);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("[TB] FAIL %s: observed empty scoreboard, expected an entry", tag);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Waits for tx_en, checks grant/byte against the scoreboard, then acks.
    task automatic apply_stimulus(input int lat, input int ack_delay, input logic [3:0] req_next,
                                  input logic [3:0] lock_next, input logic [31:0] data_next,
                                  input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (tx_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " tx_en"}, 32'(tx_en), 32'd1);
        if (lat >= 0) check_output({tag, " latency"}, 32'(n), 32'(lat));
        pop_exp(tag, e);
        check_output({tag, " grant"}, 32'(grant), 32'(e.grant));
        check_output({tag, " tx_data"}, 32'(tx_data), 32'(e.data));
        req      = req_next;
        lock     = lock_next;
        req_data = data_next;
        repeat (ack_delay) @(negedge clk);
        check_output({tag, " tx_data held"}, 32'(tx_data), 32'(e.data));
        check_output({tag, " grant held"}, 32'(grant), 32'(e.grant));
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        check_output({tag, " done"}, 32'(done), 32'(e.grant));
        check_output({tag, " err"}, 32'(err), 32'd0);
        check_output({tag, " grant cleared"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int         n;
        logic       saw_en;
        exp_t       e;
        logic [3:0] order [8];
        logic [3:0] lock_order [5];

        rst = 1'b1;
        req = '0; lock = '0; req_data = '0; tx_busy = 1'b0; tx_ack = 1'b0;
        w_req = '0; w_lock = '0; w_data = '0; w_busy = 1'b0; w_ack = 1'b0;
        apply_reset();
        check_output("reset grant", 32'(grant), 32'd0);
        check_output("reset tx_en", 32'(tx_en), 32'd0);
        check_output("reset tx_data", 32'(tx_data), 32'd0);
        check_output("reset done/err", 32'({done, err}), 32'd0);

        $display("[TB] single byte, req dropped and data changed after grant");
        req = 4'b0001;
        req_data = 32'h0000_0055;
        exp_q.push_back('{4'b0001, 8'h55});
        apply_stimulus(1, 40, 4'b0000, 4'b0000, 32'hDEAD_BEEF, "single");
        @(negedge clk);
        check_output("single done one cycle", 32'(done), 32'd0);

        $display("[TB] round robin over 8 transfers");
        apply_reset();
        req = 4'b1111;
        req_data = 32'hA3A2_A1A0;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{order[i], 8'hA0 + 8'(i % 4)});
            apply_stimulus(1, 3, 4'b1111, 4'b0000, 32'hA3A2_A1A0, $sformatf("rr%0d", i));
        end

        $display("[TB] packet lock on requester 0");
        apply_reset();
        req = 4'b0011;
        req_data = 32'h0000_B1B0;
        lock_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{lock_order[i], (i < 4) ? 8'hB0 : 8'hB1});
            apply_stimulus(1, 2, 4'b0011, (i < 3) ? 4'b0001 : 4'b0000, 32'h0000_B1B0,
                           $sformatf("lock%0d", i));
        end

        $display("[TB] transmitter busy holds off the start strobe");
        apply_reset();
        tx_busy = 1'b1;
        req = 4'b0100;
        req_data = 32'h003C_0000;
        saw_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_ack = (i == 3);
            @(negedge clk);
            if (tx_en === 1'b1) saw_en = 1'b1;
            if (i == 3) check_output("idle ack ignored", 32'(done), 32'd0);
        end
        tx_ack = 1'b0;
        check_output("busy no tx_en", 32'(saw_en), 32'd0);
        tx_busy = 1'b0;
        exp_q.push_back('{4'b0100, 8'h3C});
        apply_stimulus(1, 2, 4'b0000, 4'b0000, 32'h003C_0000, "busy");

        $display("[TB] reset during WAIT");
        apply_reset();
        req = 4'b0010;
        req_data = 32'h0000_5A00;
        n = 0;
        while (tx_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("rstwait tx_en", 32'(tx_en), 32'd1);
        check_output("rstwait grant", 32'(grant), 32'b0010);
        req = 4'b1111;
        req_data = 32'h0000_5AC3;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rstwait grant cleared", 32'(grant), 32'd0);
        check_output("rstwait no done/err", 32'({done, err}), 32'd0);
        check_output("rstwait tx_en low", 32'(tx_en), 32'd0);
        exp_q.push_back('{4'b0001, 8'hC3});
        apply_stimulus(1, 2, 4'b0000, 4'b0000, 32'h0000_5AC3, "post-reset");

        $display("[TB] watchdog timeout with 4-bit counter");
        w_req = 4'b0010;
        w_data = 32'h0000_7700;
        exp_q.push_back('{4'b0010, 8'h77});
        n = 0;
        while (w_tx_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("wd tx_en", 32'(w_tx_en), 32'd1);
        pop_exp("wd first", e);
        check_output("wd grant", 32'(w_grant), 32'(e.grant));
        check_output("wd tx_data", 32'(w_tx_data), 32'(e.data));
        w_req = 4'b0101;
        w_data = 32'h0044_0011;
        repeat (16) @(negedge clk);
        check_output("wd err not early", 32'(w_err), 32'd0);
        @(negedge clk);
        check_output("wd err", 32'(w_err), 32'b0010);
        check_output("wd no done", 32'(w_done), 32'd0);
        check_output("wd grant cleared", 32'(w_grant), 32'd0);
        exp_q.push_back('{4'b0100, 8'h44});
        n = 0;
        while (w_tx_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("wd regrant latency", 32'(n), 32'd1);
        pop_exp("wd second", e);
        check_output("wd regrant", 32'(w_grant), 32'(e.grant));
        check_output("wd regrant data", 32'(w_tx_data), 32'(e.data));
        w_req = 4'b0000;
        repeat (2) @(negedge clk);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        check_output("wd regrant done", 32'(w_done), 32'b0100);
        check_output("wd regrant no err", 32'(w_err), 32'd0);

        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
